// File: rtl/ctrl_pkg.sv
// Shared decode definitions for the ID stage: RV32I opcode/funct constants,
// ALU operation codes, write-back select encodings and the EX control bundle.
package ctrl_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB  = 5'd1,  ALU_SLL    = 5'd2,  ALU_SLT   = 5'd3,
        ALU_SLTU   = 5'd4,  ALU_XOR  = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
        ALU_OR     = 5'd8,  ALU_AND  = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH  = 5'd11,
        ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV   = 5'd14, ALU_DIVU  = 5'd15,
        ALU_REM    = 5'd16, ALU_REMU = 5'd17
    } alu_op_e;

    localparam logic [1:0] WB_LSU = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef struct packed {
        logic             lui_sel;
        logic             rd_wren;
        logic             insn_vld;
        logic             br_un;
        logic             opa_sel;   // 1: PC as operand A
        logic             opb_sel;   // 1: immediate as operand B
        logic             mem_wren;
        logic             isload;
        logic             is_branch;
        logic             is_jump;
        logic [1:0]       wb_sel;
        alu_op_e          alu_op;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
    } ctrl_bundle_t;

    // All-zero bundle: every flag clear, wb_sel=LSU, alu_op=ADD, indices x0.
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Base-ISA funct3 to ALU op; alt selects SUB/SRA.
    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  base_alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  base_alu_op = ALU_SLL;
            3'b010:  base_alu_op = ALU_SLT;
            3'b011:  base_alu_op = ALU_SLTU;
            3'b100:  base_alu_op = ALU_XOR;
            3'b101:  base_alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  base_alu_op = ALU_OR;
            default: base_alu_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_decode_core.sv
// Combinational RV32I(+M) decoder.
// Ports: i_instr (32b instruction) -> o_ctrl (EX control bundle),
//        o_rs1_used / o_rs2_used (source register actually read).
// Unread/unwritten register indices are zeroed; illegal encodings yield a bubble.
module id_decode_core
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_MEXT = 0
) (
    input  logic [31:0]  i_instr,
    output ctrl_bundle_t o_ctrl,
    output logic         o_rs1_used,
    output logic         o_rs2_used
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       legal;

    assign opc = i_instr[6:0];
    assign f3  = i_instr[14:12];
    assign f7  = i_instr[31:25];

    always_comb begin
        o_ctrl     = CTRL_BUBBLE;
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
        legal      = 1'b0;

        case (opc)
            OPC_OP: begin
                o_rs1_used     = 1'b1;
                o_rs2_used     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
                if (f7 == F7_BASE) begin
                    legal         = 1'b1;
                    o_ctrl.alu_op = base_alu_op(f3, 1'b0);
                end else if (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA)) begin
                    legal         = 1'b1;
                    o_ctrl.alu_op = base_alu_op(f3, 1'b1);
                end else if (f7 == F7_MEXT && EN_MEXT != 0) begin
                    legal         = 1'b1;
                    o_ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + {2'b00, f3});
                end
            end
            OPC_OP_IMM: begin
                o_rs1_used     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.opb_sel = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
                o_ctrl.alu_op  = base_alu_op(f3, (f3 == F3_SRL_SRA) && i_instr[30]);
                if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
                else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                       legal = 1'b1;
            end
            OPC_LOAD: begin
                legal          = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                o_rs1_used     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.opb_sel = 1'b1;
                o_ctrl.isload  = 1'b1;
                o_ctrl.wb_sel  = WB_LSU;
            end
            OPC_STORE: begin
                legal           = (f3[2] == 1'b0) && (f3 != 3'b011);
                o_rs1_used      = 1'b1;
                o_rs2_used      = 1'b1;
                o_ctrl.opb_sel  = 1'b1;
                o_ctrl.mem_wren = 1'b1;
            end
            OPC_BRANCH: begin
                legal            = (f3 != 3'b010) && (f3 != 3'b011);
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
                o_ctrl.is_branch = 1'b1;
                o_ctrl.br_un     = f3[2] & f3[1];
                // BEQ/BNE compare via SUB, BLT/BGE via SLT, BLTU/BGEU via SLTU
                o_ctrl.alu_op    = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
            end
            OPC_LUI: begin
                legal          = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.lui_sel = 1'b1;
                o_ctrl.opb_sel = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
            end
            OPC_AUIPC: begin
                legal          = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.opa_sel = 1'b1;
                o_ctrl.opb_sel = 1'b1;
                o_ctrl.wb_sel  = WB_ALU;
            end
            OPC_JAL: begin
                legal          = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.is_jump = 1'b1;
                o_ctrl.opa_sel = 1'b1;
                o_ctrl.opb_sel = 1'b1;
                o_ctrl.wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                legal          = (f3 == F3_JALR);
                o_rs1_used     = 1'b1;
                o_ctrl.rd_wren = 1'b1;
                o_ctrl.is_jump = 1'b1;
                o_ctrl.opb_sel = 1'b1;
                o_ctrl.wb_sel  = WB_PC4;
            end
            default: legal = 1'b0;
        endcase

        o_ctrl.insn_vld = legal;
        o_ctrl.rd       = o_ctrl.rd_wren ? i_instr[11:7]  : '0;
        o_ctrl.rs1      = o_rs1_used     ? i_instr[19:15] : '0;
        o_ctrl.rs2      = o_rs2_used     ? i_instr[24:20] : '0;

        if (!legal) begin
            o_ctrl     = CTRL_BUBBLE;
            o_rs1_used = 1'b0;
            o_rs2_used = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// ID stage control: decode, ID/EX control register, RAW scoreboard, stall/flush
// priority and saturating event counters.
// Ports: i_clk, i_reset (sync, active-high), i_instr/i_instr_vld (IF/ID),
//        i_flush (EX redirect), i_hold (global freeze), o_id_stall (combinational),
//        o_ex_* (registered ID/EX bundle), o_stall_cnt/o_flush_cnt.
module id_stage_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned EN_MEXT   = 0,
    parameter int unsigned HAZ_DEPTH = 3,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned ALU_OP_W  = (EN_MEXT != 0) ? 5 : 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [31:0]         i_instr,
    input  logic                i_instr_vld,
    input  logic                i_flush,
    input  logic                i_hold,
    output logic                o_id_stall,
    output logic                o_ex_vld,
    output logic                o_ex_lui_sel,
    output logic                o_ex_rd_wren,
    output logic                o_ex_insn_vld,
    output logic                o_ex_br_un,
    output logic                o_ex_opa_sel,
    output logic                o_ex_opb_sel,
    output logic                o_ex_mem_wren,
    output logic                o_ex_isload,
    output logic                o_ex_is_branch,
    output logic                o_ex_is_jump,
    output logic [1:0]          o_ex_wb_sel,
    output logic [ALU_OP_W-1:0] o_ex_alu_op,
    output logic [4:0]          o_ex_rd,
    output logic [4:0]          o_ex_rs1,
    output logic [4:0]          o_ex_rs2,
    output logic [CNT_W-1:0]    o_stall_cnt,
    output logic [CNT_W-1:0]    o_flush_cnt
);

    ctrl_bundle_t dec;
    logic         rs1_used;
    logic         rs2_used;

    id_decode_core #(.EN_MEXT(EN_MEXT)) u_decode (
        .i_instr    (i_instr),
        .o_ctrl     (dec),
        .o_rs1_used (rs1_used),
        .o_rs2_used (rs2_used)
    );

    ctrl_bundle_t                      ex_q;
    logic                              ex_vld_q;
    logic [HAZ_DEPTH-1:0]              sb_vld;
    logic [HAZ_DEPTH-1:0][REG_W-1:0]   sb_rd;
    logic [CNT_W-1:0]                  stall_cnt_q;
    logic [CNT_W-1:0]                  flush_cnt_q;
    logic                              rs1_hit;
    logic                              rs2_hit;
    logic                              hazard;

    // Compare used sources against every in-flight destination; valid entries never hold x0.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_vld[i] && sb_rd[i] == dec.rs1) rs1_hit = 1'b1;
            if (sb_vld[i] && sb_rd[i] == dec.rs2) rs2_hit = 1'b1;
        end
    end

    assign hazard     = i_instr_vld & ((rs1_used & rs1_hit) | (rs2_used & rs2_hit));
    assign o_id_stall = ~i_reset & (i_hold | (~i_flush & hazard));

    // ID/EX register, scoreboard shift and counters: reset > hold > flush > hazard > issue.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ex_q        <= CTRL_BUBBLE;
            ex_vld_q    <= 1'b0;
            sb_vld      <= '0;
            sb_rd       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!i_hold) begin
            for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
                sb_vld[i] <= sb_vld[i-1];
                sb_rd[i]  <= sb_rd[i-1];
            end
            sb_vld[0] <= 1'b0;
            sb_rd[0]  <= '0;
            ex_q      <= CTRL_BUBBLE;
            ex_vld_q  <= 1'b0;

            if (i_flush) begin
                if (flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else if (hazard) begin
                if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else if (i_instr_vld) begin
                ex_q      <= dec;
                ex_vld_q  <= 1'b1;
                sb_vld[0] <= dec.rd_wren && (dec.rd != '0);
                sb_rd[0]  <= dec.rd;
            end
        end
    end

    assign o_ex_vld       = ex_vld_q;
    assign o_ex_lui_sel   = ex_q.lui_sel;
    assign o_ex_rd_wren   = ex_q.rd_wren;
    assign o_ex_insn_vld  = ex_q.insn_vld;
    assign o_ex_br_un     = ex_q.br_un;
    assign o_ex_opa_sel   = ex_q.opa_sel;
    assign o_ex_opb_sel   = ex_q.opb_sel;
    assign o_ex_mem_wren  = ex_q.mem_wren;
    assign o_ex_isload    = ex_q.isload;
    assign o_ex_is_branch = ex_q.is_branch;
    assign o_ex_is_jump   = ex_q.is_jump;
    assign o_ex_wb_sel    = ex_q.wb_sel;
    assign o_ex_alu_op    = ALU_OP_W'(ex_q.alu_op);
    assign o_ex_rd        = ex_q.rd;
    assign o_ex_rs1       = ex_q.rs1;
    assign o_ex_rs2       = ex_q.rs2;
    assign o_stall_cnt    = stall_cnt_q;
    assign o_flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed bench for id_stage_ctrl: a base instance (no M, 32b counters) and an
// M-enabled instance with 2-bit counters sharing the same stimulus.
module tb_id_stage_ctrl;

    localparam logic [31:0] ADD_X3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] ADDI_X5 = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] ADD_X6  = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] LW_X7   = 32'h0000A383; // lw   x7,0(x1)
    localparam logic [31:0] LUI_X7  = 32'h000013B7; // lui  x7,1
    localparam logic [31:0] ADDI_X8 = 32'h00200413; // addi x8,x0,2
    localparam logic [31:0] ADD_X9  = 32'h008404B3; // add  x9,x8,x8
    localparam logic [31:0] MUL_X0  = 32'h02208033; // mul  x0,x1,x2
    localparam logic [31:0] SW_X2   = 32'h0020A223; // sw   x2,4(x1)
    localparam logic [31:0] BLTU    = 32'h0020E063; // bltu x1,x2,0
    localparam logic [31:0] JAL_X1  = 32'h000000EF; // jal  x1,0
    localparam logic [31:0] ILLEGAL = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, vld, flush, hold;
    logic [31:0] instr;

    logic        stall, ex_vld, lui_sel, rd_wren, insn_vld, br_un, opa_sel, opb_sel;
    logic        mem_wren, isload, is_branch, is_jump;
    logic [1:0]  wb_sel;
    logic [3:0]  alu_op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] stall_cnt, flush_cnt;

    logic        m_stall, m_ex_vld, m_lui_sel, m_rd_wren, m_insn_vld, m_br_un, m_opa_sel;
    logic        m_opb_sel, m_mem_wren, m_isload, m_is_branch, m_is_jump;
    logic [1:0]  m_wb_sel;
    logic [4:0]  m_alu_op;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [1:0]  m_stall_cnt, m_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_stage_ctrl #(.EN_MEXT(0), .HAZ_DEPTH(3), .CNT_W(32)) dut (
        .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_instr_vld(vld),
        .i_flush(flush), .i_hold(hold), .o_id_stall(stall), .o_ex_vld(ex_vld),
        .o_ex_lui_sel(lui_sel), .o_ex_rd_wren(rd_wren), .o_ex_insn_vld(insn_vld),
        .o_ex_br_un(br_un), .o_ex_opa_sel(opa_sel), .o_ex_opb_sel(opb_sel),
        .o_ex_mem_wren(mem_wren), .o_ex_isload(isload), .o_ex_is_branch(is_branch),
        .o_ex_is_jump(is_jump), .o_ex_wb_sel(wb_sel), .o_ex_alu_op(alu_op),
        .o_ex_rd(rd), .o_ex_rs1(rs1), .o_ex_rs2(rs2),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    id_stage_ctrl #(.EN_MEXT(1), .HAZ_DEPTH(3), .CNT_W(2)) dut_m (
        .i_clk(clk), .i_reset(rst), .i_instr(instr), .i_instr_vld(vld),
        .i_flush(flush), .i_hold(hold), .o_id_stall(m_stall), .o_ex_vld(m_ex_vld),
        .o_ex_lui_sel(m_lui_sel), .o_ex_rd_wren(m_rd_wren), .o_ex_insn_vld(m_insn_vld),
        .o_ex_br_un(m_br_un), .o_ex_opa_sel(m_opa_sel), .o_ex_opb_sel(m_opb_sel),
        .o_ex_mem_wren(m_mem_wren), .o_ex_isload(m_isload), .o_ex_is_branch(m_is_branch),
        .o_ex_is_jump(m_is_jump), .o_ex_wb_sel(m_wb_sel), .o_ex_alu_op(m_alu_op),
        .o_ex_rd(m_rd), .o_ex_rs1(m_rs1), .o_ex_rs2(m_rs2),
        .o_stall_cnt(m_stall_cnt), .o_flush_cnt(m_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present an instruction, check the combinational stall, then advance one edge.
    task automatic step(input logic [31:0] ins, input logic v, input logic exp_stall,
                        input string tag);
        instr = ins;
        vld   = v;
        #1;
        check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; hold = 1'b1; flush = 1'b0; vld = 1'b1; instr = ADD_X3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",     32'(stall), 0);
        check("rst_ex_vld",    32'(ex_vld), 0);
        check("rst_rd_wren",   32'(rd_wren), 0);
        check("rst_wb_sel",    32'(wb_sel), 0);
        check("rst_rd",        32'(rd), 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        rst = 1'b0; hold = 1'b0;

        // Plain R-type issue
        step(ADD_X3, 1'b1, 1'b0, "add");
        check("add_ex_vld",  32'(ex_vld), 1);
        check("add_alu_op",  32'(alu_op), 0);
        check("add_wb_sel",  32'(wb_sel), 1);
        check("add_rd",      32'(rd), 3);
        check("add_rd_wren", 32'(rd_wren), 1);
        check("add_rs1",     32'(rs1), 1);
        check("add_rs2",     32'(rs2), 2);

        // Back-to-back RAW: three stall bubbles then issue
        step(ADDI_X5, 1'b1, 1'b0, "addi");
        check("addi_opb_sel", 32'(opb_sel), 1);
        check("addi_rd",      32'(rd), 5);
        for (int k = 0; k < 3; k++) begin
            step(ADD_X6, 1'b1, 1'b1, "raw");
            check("raw_bubble", 32'(ex_vld), 0);
        end
        step(ADD_X6, 1'b1, 1'b0, "raw_go");
        check("raw_issue_rd",  32'(rd), 6);
        check("raw_stall_cnt", stall_cnt, 3);
        check("raw_m_stall_cnt", 32'(m_stall_cnt), 3);

        // Load then LUI to same rd: no source use, no stall
        step(LW_X7, 1'b1, 1'b0, "lw");
        check("lw_isload", 32'(isload), 1);
        check("lw_wb_sel", 32'(wb_sel), 0);
        step(LUI_X7, 1'b1, 1'b0, "lui");
        check("lui_sel",       32'(lui_sel), 1);
        check("lui_rs1",       32'(rs1), 0);
        check("lui_stall_cnt", stall_cnt, 3);

        // Flush during a stall
        step(ADDI_X8, 1'b1, 1'b0, "addi8");
        step(ADD_X9, 1'b1, 1'b1, "pre_flush");
        flush = 1'b1;
        step(ADD_X9, 1'b1, 1'b0, "flush");
        flush = 1'b0;
        check("flush_ex_vld",    32'(ex_vld), 0);
        check("flush_cnt",       flush_cnt, 1);
        check("flush_stall_cnt", stall_cnt, 4);
        step(ADD_X9, 1'b1, 1'b1, "post_flush");
        step(ADD_X9, 1'b1, 1'b0, "post_flush_go");
        check("post_flush_rd", 32'(rd), 9);

        // Hold freezes ID/EX and counters; the full stall count remains after release
        step(ADDI_X5, 1'b1, 1'b0, "addi_h");
        hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(ADD_X6, 1'b1, 1'b1, "hold");
            check("hold_ex_vld",    32'(ex_vld), 1);
            check("hold_rd",        32'(rd), 5);
            check("hold_stall_cnt", stall_cnt, 5);
        end
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(ADD_X6, 1'b1, 1'b1, "held_raw");
            check("held_raw_bubble", 32'(ex_vld), 0);
        end
        step(ADD_X6, 1'b1, 1'b0, "held_go");
        check("held_issue_rd", 32'(rd), 6);
        check("held_stall_cnt", stall_cnt, 8);
        check("sat_m_stall_cnt", 32'(m_stall_cnt), 3);
        check("m_flush_cnt", 32'(m_flush_cnt), 1);

        // Reset mid-stall clears the scoreboard
        step(ADDI_X5, 1'b1, 1'b0, "addi_r");
        step(ADD_X6, 1'b1, 1'b1, "pre_rst");
        rst = 1'b1;
        step(ADD_X6, 1'b1, 1'b0, "in_rst");
        rst = 1'b0;
        check("rst2_ex_vld",    32'(ex_vld), 0);
        check("rst2_stall_cnt", stall_cnt, 0);
        check("rst2_flush_cnt", flush_cnt, 0);
        step(ADD_X6, 1'b1, 1'b0, "after_rst");
        check("after_rst_ex_vld", 32'(ex_vld), 1);
        check("after_rst_rd",     32'(rd), 6);

        // Invalid IF/ID slot: bubble, no stall despite matching source
        step(ADDI_X5, 1'b1, 1'b0, "addi_v");
        step(ADD_X6, 1'b0, 1'b0, "novld");
        check("novld_ex_vld",    32'(ex_vld), 0);
        check("novld_stall_cnt", stall_cnt, 0);

        // MUL: illegal without M, ALU op 10 with M
        step(MUL_X0, 1'b1, 1'b0, "mul");
        check("mul_ex_vld",     32'(ex_vld), 1);
        check("mul_insn_vld",   32'(insn_vld), 0);
        check("mul_rd_wren",    32'(rd_wren), 0);
        check("mul_m_alu_op",   32'(m_alu_op), 10);
        check("mul_m_rd_wren",  32'(m_rd_wren), 1);
        check("mul_m_insn_vld", 32'(m_insn_vld), 1);

        step(ILLEGAL, 1'b1, 1'b0, "ill");
        check("ill_insn_vld", 32'(insn_vld), 0);
        check("ill_mem_wren", 32'(mem_wren), 0);
        check("ill_rd_wren",  32'(rd_wren), 0);

        step(SW_X2, 1'b1, 1'b0, "sw");
        check("sw_mem_wren", 32'(mem_wren), 1);
        check("sw_rd_wren",  32'(rd_wren), 0);
        check("sw_rd",       32'(rd), 0);
        check("sw_rs2",      32'(rs2), 2);

        step(BLTU, 1'b1, 1'b0, "bltu");
        check("bltu_is_branch", 32'(is_branch), 1);
        check("bltu_br_un",     32'(br_un), 1);
        check("bltu_alu_op",    32'(alu_op), 4);

        step(JAL_X1, 1'b1, 1'b0, "jal");
        check("jal_is_jump", 32'(is_jump), 1);
        check("jal_wb_sel",  32'(wb_sel), 2);
        check("jal_opa_sel", 32'(opa_sel), 1);
        check("jal_rd",      32'(rd), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
